// File: rtl/dispatch_packet_gather_pkg.sv
// Shared configuration, derived widths, packet types and slicing helpers
// for the execute-side dispatch packet gatherer.
package dispatch_packet_gather_pkg;

  localparam int ISSUE_WIDTH = 4;
  localparam int NUM_THREADS = 8;
  localparam int NUM_LANES   = 4;
  localparam int XLEN        = 32;
  localparam int HDR_W       = 64;

  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;
  localparam int PID_W       = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;
  localparam int ISW_W       = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;

  typedef logic [HDR_W-1:0]                      hdr_t;
  typedef logic [NUM_THREADS-1:0]                tmask_t;
  typedef logic [2:0][NUM_THREADS-1:0][XLEN-1:0] rs_t;
  typedef logic [NUM_LANES-1:0]                  lmask_t;
  typedef logic [2:0][NUM_LANES-1:0][XLEN-1:0]   lrs_t;
  typedef logic [PID_W-1:0]                      pid_t;
  typedef logic [ISW_W-1:0]                      isw_t;
  typedef logic [NUM_PACKETS-1:0]                nz_t;

  typedef struct packed {
    hdr_t   hdr;
    lmask_t tmask;
    lrs_t   rs;
    pid_t   pid;
    logic   sop;
    logic   eop;
    isw_t   isw;
  } pkt_t;

  function automatic lmask_t slice_tmask(tmask_t tm, pid_t pid);
    return tm[int'(pid)*NUM_LANES +: NUM_LANES];
  endfunction

  function automatic lrs_t slice_rs(rs_t rs, pid_t pid);
    lrs_t s;
    s = '0;
    for (int r = 0; r < 3; r++) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        s[r][l] = rs[r][int'(pid)*NUM_LANES + l];
      end
    end
    return s;
  endfunction

  // One flag per packet slot: set when that lane group has any active thread.
  function automatic nz_t slice_nz(tmask_t tm);
    nz_t nz;
    nz = '0;
    for (int p = 0; p < NUM_PACKETS; p++) begin
      nz[p] = |tm[p*NUM_LANES +: NUM_LANES];
    end
    return nz;
  endfunction

endpackage

// File: rtl/dispatch_packet_gather_if.sv
// Dispatch-side input slots and lane-width output stream of the gatherer.
// master = upstream/downstream environment, slave = the gatherer itself.
interface dispatch_packet_gather_if;
  import dispatch_packet_gather_pkg::*;

  logic [ISSUE_WIDTH-1:0]   in_valid;
  logic [ISSUE_WIDTH-1:0]   in_ready;
  hdr_t [ISSUE_WIDTH-1:0]   in_hdr;
  tmask_t [ISSUE_WIDTH-1:0] in_tmask;
  rs_t [ISSUE_WIDTH-1:0]    in_rs;

  logic   out_valid;
  logic   out_ready;
  hdr_t   out_hdr;
  lmask_t out_tmask;
  lrs_t   out_rs;
  pid_t   out_pid;
  logic   out_sop;
  logic   out_eop;
  isw_t   out_isw;

  modport master (
    output in_valid, in_hdr, in_tmask, in_rs, out_ready,
    input  in_ready, out_valid, out_hdr, out_tmask, out_rs,
           out_pid, out_sop, out_eop, out_isw
  );

  modport slave (
    input  in_valid, in_hdr, in_tmask, in_rs, out_ready,
    output in_ready, out_valid, out_hdr, out_tmask, out_rs,
           out_pid, out_sop, out_eop, out_isw
  );

endinterface

// File: rtl/dispatch_rr_arbiter.sv
// Round-robin slot selector; while locked it keeps pointing at the locked
// slot so an instruction is never interleaved with another.
module dispatch_rr_arbiter
  import dispatch_packet_gather_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ISSUE_WIDTH-1:0] i_req,
  input  logic                   i_lock,
  input  isw_t                   i_lock_isw,
  input  logic                   i_advance,
  output isw_t                   o_gnt_isw,
  output logic                   o_gnt_valid
);

  isw_t r_rr_ptr;
  int   w_idx;

  always_comb begin
    o_gnt_isw   = i_lock_isw;
    o_gnt_valid = 1'b0;
    w_idx       = 0;
    if (i_lock) begin
      o_gnt_valid = i_req[i_lock_isw];
    end else begin
      // Walk from farthest to nearest so the slot right after r_rr_ptr wins.
      for (int k = ISSUE_WIDTH; k >= 1; k--) begin
        w_idx = (int'(r_rr_ptr) + k) % ISSUE_WIDTH;
        if (i_req[isw_t'(w_idx)]) begin
          o_gnt_isw   = isw_t'(w_idx);
          o_gnt_valid = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= isw_t'(ISSUE_WIDTH - 1);
    end else if (i_advance) begin
      r_rr_ptr <= o_gnt_isw;
    end
  end

endmodule

// File: rtl/dispatch_packet_gather.sv
// Gathers per-slot dispatch streams onto one lane-width stream, slicing each
// instruction into packets and skipping lane groups with no active thread.
module dispatch_packet_gather
  import dispatch_packet_gather_pkg::*;
(
  input logic clk,
  input logic reset,
  dispatch_packet_gather_if.slave io
);

  // state  | meaning
  // S_IDLE | no lock; next push starts a new instruction from the arbiter
  // S_BUSY | locked to r_lock_isw, emitting packet r_cur_pid next
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t r_state, w_state_nxt;
  isw_t   r_lock_isw, w_lock_isw_nxt;
  pid_t   r_cur_pid, w_cur_pid_nxt;
  pkt_t   r_pkt, w_pkt;
  logic   r_out_valid;

  isw_t w_sel;
  logic w_sel_valid;
  nz_t  w_nz;
  pid_t w_pid, w_next_pid;
  logic w_has_next, w_eop, w_push;

  dispatch_rr_arbiter u_arb (
    .clk         (clk),
    .reset       (reset),
    .i_req       (io.in_valid),
    .i_lock      (r_state == S_BUSY),
    .i_lock_isw  (r_lock_isw),
    .i_advance   (w_push && w_eop),
    .o_gnt_isw   (w_sel),
    .o_gnt_valid (w_sel_valid)
  );

  always_comb begin
    w_nz       = slice_nz(io.in_tmask[w_sel]);
    w_pid      = r_cur_pid;
    w_next_pid = '0;
    w_has_next = 1'b0;
    if (r_state == S_IDLE) begin
      w_pid = '0;
      for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
        if (w_nz[p]) w_pid = pid_t'(p);
      end
    end
    // An all-zero mask falls through with pid 0 and no successor: one packet.
    for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
      if (w_nz[p] && (p > int'(w_pid))) begin
        w_next_pid = pid_t'(p);
        w_has_next = 1'b1;
      end
    end
    w_eop  = !w_has_next;
    w_push = reset && w_sel_valid && (!r_out_valid || io.out_ready);

    w_pkt.hdr   = io.in_hdr[w_sel];
    w_pkt.tmask = slice_tmask(io.in_tmask[w_sel], w_pid);
    w_pkt.rs    = slice_rs(io.in_rs[w_sel], w_pid);
    w_pkt.pid   = w_pid;
    w_pkt.sop   = (r_state == S_IDLE);
    w_pkt.eop   = w_eop;
    w_pkt.isw   = w_sel;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_isw_nxt = r_lock_isw;
    w_cur_pid_nxt  = r_cur_pid;
    io.in_ready    = '0;
    if (w_push) begin
      if (w_eop) begin
        w_state_nxt           = S_IDLE;
        w_cur_pid_nxt         = '0;
        io.in_ready[w_sel]    = 1'b1;
      end else begin
        w_state_nxt    = S_BUSY;
        w_lock_isw_nxt = w_sel;
        w_cur_pid_nxt  = w_next_pid;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_lock_isw <= '0;
      r_cur_pid  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_isw <= w_lock_isw_nxt;
      r_cur_pid  <= w_cur_pid_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_pkt       <= '0;
    end else if (w_push) begin
      r_out_valid <= 1'b1;
      r_pkt       <= w_pkt;
    end else if (r_out_valid && io.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign io.out_valid = r_out_valid;
  assign io.out_hdr   = r_pkt.hdr;
  assign io.out_tmask = r_pkt.tmask;
  assign io.out_rs    = r_pkt.rs;
  assign io.out_pid   = r_pkt.pid;
  assign io.out_sop   = r_pkt.sop;
  assign io.out_eop   = r_pkt.eop;
  assign io.out_isw   = r_pkt.isw;

endmodule
